// File: rtl/switch_pkg.sv
// Shared types and constants for the port dispatch switch: FSM state encoding,
// default geometry and the minimum legal packet length.
package switch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int unsigned DEF_W_WIDTH = 8;
  localparam int unsigned DEF_N_PORTS = 4;
  localparam int unsigned DEF_MAX_LEN = 64;
  localparam int unsigned MIN_PKT_LEN = 3;

endpackage

// File: rtl/port_dispatch_fsm_wd_cnt.sv
// Beat counter for one packet: clear/increment, saturating at MAX_LEN, with a
// flag that says the beat arriving now would take the packet past MAX_LEN.
module wd_cnt
  import switch_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  localparam int unsigned CW     = $clog2(MAX_LEN + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          over_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear together with increment loads 1, so the first beat can restart the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CW'(1) : '0;
    end else if (inc_i && !over_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign over_o = (32'(cnt_q) + 32'd1) > MAX_LEN;

endmodule

// File: rtl/port_dispatch_fsm.sv
// Packet dispatcher: matches the address beat against the port table, forwards
// the packet to one port and reports parity, length and drop status.
module port_dispatch_fsm
  import switch_pkg::*;
#(
  parameter int unsigned W_WIDTH = DEF_W_WIDTH,
  parameter int unsigned N_PORTS = DEF_N_PORTS,
  parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sw_en,
  input  logic [W_WIDTH-1:0]           data_in,
  input  logic [N_PORTS*W_WIDTH-1:0]   port_addr,
  input  logic [N_PORTS-1:0]           port_busy,
  output logic [N_PORTS-1:0]           wr_en,
  output logic [W_WIDTH-1:0]           data_out,
  output logic                         pkt_ok,
  output logic                         err_parity,
  output logic                         err_len,
  output logic                         err_drop,
  output state_e                       dbg_state
);

  localparam int unsigned CW = $clog2(MAX_LEN + 2);

  // Framing: sw_en high frames one packet (address, data, parity); there is no
  // back-pressure. A packet starts only on a rising sw_en seen in IDLE.
  state_e               state_q, state_d;
  logic [N_PORTS-1:0]   sel_q, sel_d;
  logic [W_WIDTH-1:0]   xor_q, xor_d;
  logic [N_PORTS-1:0]   wr_en_q, wr_en_d;
  logic [W_WIDTH-1:0]   dout_q, dout_d;
  logic                 ok_q, ok_d, par_q, par_d, len_q, len_d, drop_q, drop_d;
  logic                 sw_en_q;
  logic                 cnt_clr, cnt_inc, cnt_over;
  logic [CW-1:0]        cnt;
  logic [N_PORTS-1:0]   match_oh;
  logic                 match_found;
  logic                 sop;

  wd_cnt #(.MAX_LEN(MAX_LEN)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .over_o (cnt_over)
  );

  // Lowest index wins on duplicate addresses.
  always_comb begin
    match_oh    = '0;
    match_found = 1'b0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (!match_found && port_addr[i*W_WIDTH +: W_WIDTH] == data_in) begin
        match_oh[i] = 1'b1;
        match_found = 1'b1;
      end
    end
  end

  assign sop = sw_en && !sw_en_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    xor_d   = xor_q;
    wr_en_d = '0;
    dout_d  = dout_q;
    ok_d    = 1'b0;
    par_d   = 1'b0;
    len_d   = 1'b0;
    drop_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sop) begin
          cnt_clr = 1'b1;
          if (match_found && (match_oh & port_busy) == '0) begin
            state_d = FWD;
            sel_d   = match_oh;
            wr_en_d = match_oh;
            dout_d  = data_in;
            xor_d   = data_in;
            cnt_inc = 1'b1;
          end else begin
            state_d = DROP;
            drop_d  = 1'b1;
          end
        end
      end
      FWD: begin
        if (!sw_en) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          xor_d   = '0;
          if (32'(cnt) < MIN_PKT_LEN) len_d = 1'b1;
          else if (xor_q != '0)       par_d = 1'b1;
          else                        ok_d  = 1'b1;
        end else if (cnt_over) begin
          state_d = DROP;
          len_d   = 1'b1;
          cnt_clr = 1'b1;
          xor_d   = '0;
        end else if ((sel_q & port_busy) != '0) begin
          state_d = DROP;
          drop_d  = 1'b1;
          cnt_clr = 1'b1;
          xor_d   = '0;
        end else begin
          wr_en_d = sel_q;
          dout_d  = data_in;
          xor_d   = xor_q ^ data_in;
          cnt_inc = 1'b1;
        end
      end
      DROP: begin
        if (!sw_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      xor_q   <= '0;
      wr_en_q <= '0;
      dout_q  <= '0;
      ok_q    <= 1'b0;
      par_q   <= 1'b0;
      len_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      xor_q   <= xor_d;
      wr_en_q <= wr_en_d;
      dout_q  <= dout_d;
      ok_q    <= ok_d;
      par_q   <= par_d;
      len_q   <= len_d;
      drop_q  <= drop_d;
    end
  end

  // Sampled through reset too, so a packet still running at release is ignored.
  always_ff @(posedge clk) sw_en_q <= sw_en;

  assign wr_en      = wr_en_q;
  assign data_out   = dout_q;
  assign pkt_ok     = ok_q;
  assign err_parity = par_q;
  assign err_len    = len_q;
  assign err_drop   = drop_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_port_dispatch_fsm.sv
// Self-checking bench for port_dispatch_fsm (MAX_LEN=4): vector table plus
// hand-written sequences, one expected output record per clock.
module tb_port_dispatch_fsm;
  import switch_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned NP = 4;

  typedef struct {
    logic       rst;
    logic       sw;
    logic [7:0] din;
    logic [3:0] busy;
    logic [3:0] ewr;
    logic       edv;
    logic [7:0] edout;
    logic [3:0] eflag;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sw_en = 1'b0;
  logic [W-1:0]    data_in = '0;
  logic [NP*W-1:0] port_addr = 32'h33_22_11_00;
  logic [NP-1:0]   port_busy = '0;
  logic [NP-1:0]   wr_en;
  logic [W-1:0]    data_out;
  logic            pkt_ok, err_parity, err_len, err_drop;
  state_e          dbg_state;

  logic [16:0] exp_q[$];
  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;

  localparam logic [3:0] F_OK = 4'b1000, F_PAR = 4'b0100, F_LEN = 4'b0010, F_DROP = 4'b0001;

  always #5 clk = ~clk;

  port_dispatch_fsm #(.W_WIDTH(W), .N_PORTS(NP), .MAX_LEN(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_en      (sw_en),
    .data_in    (data_in),
    .port_addr  (port_addr),
    .port_busy  (port_busy),
    .wr_en      (wr_en),
    .data_out   (data_out),
    .pkt_ok     (pkt_ok),
    .err_parity (err_parity),
    .err_len    (err_len),
    .err_drop   (err_drop),
    .dbg_state  (dbg_state)
  );

  function automatic vec_t mk(logic r, logic s, logic [7:0] d, logic [3:0] b,
                              logic [3:0] ew, logic dv, logic [7:0] ed, logic [3:0] ef);
    vec_t v;
    v.rst = r; v.sw = s; v.din = d; v.busy = b;
    v.ewr = ew; v.edv = dv; v.edout = ed; v.eflag = ef;
    return v;
  endfunction

  // Beat expected to appear on port 2 one cycle later.
  function automatic vec_t fw(logic [7:0] d, logic [3:0] b);
    return mk(1'b1, 1'b1, d, b, 4'b0100, 1'b1, d, 4'b0000);
  endfunction

  // Cycle with no write expected, only the given status flags.
  function automatic vec_t nw(logic s, logic [7:0] d, logic [3:0] b, logic [3:0] ef);
    return mk(1'b1, s, d, b, 4'b0000, 1'b0, 8'h00, ef);
  endfunction

  task automatic apply(input string name, input vec_t v);
    logic [16:0] e;
    logic [16:0] got;
    @(negedge clk);
    rst_n     = v.rst;
    sw_en     = v.sw;
    data_in   = v.din;
    port_busy = v.busy;
    exp_q.push_back({v.edv, v.ewr, v.edout, v.eflag});
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = {1'b0, wr_en, data_out, pkt_ok, err_parity, err_len, err_drop};
    checks++;
    if (got[15:12] !== e[15:12] || got[3:0] !== e[3:0] ||
        (e[16] && got[11:4] !== e[11:4])) begin
      errors++;
      $display("FAIL %s: got wr_en=%b data_out=%h ok/par/len/drop=%b, expected wr_en=%b data_out=%h%s ok/par/len/drop=%b",
               name, got[15:12], got[11:4], got[3:0], e[15:12], e[11:4],
               e[16] ? "" : "(any)", e[3:0]);
    end
  endtask

  initial begin
    // Packet framing scenarios, each line is one clock of stimulus.
    tbl.push_back(fw(8'h22, 4'h0));
    tbl.push_back(fw(8'hA5, 4'h0));
    tbl.push_back(fw(8'h87, 4'h0));
    tbl.push_back(nw(1'b0, 8'h00, 4'b0100, F_OK));     // end beats busy: end wins
    tbl.push_back(fw(8'h22, 4'h0));                    // back-to-back start
    tbl.push_back(fw(8'hA5, 4'h0));
    tbl.push_back(fw(8'h00, 4'h0));
    tbl.push_back(nw(1'b0, 8'h00, 4'h0, F_PAR));
    tbl.push_back(nw(1'b1, 8'h44, 4'h0, F_DROP));      // no match
    tbl.push_back(nw(1'b1, 8'h9A, 4'h0, 4'h0));
    tbl.push_back(nw(1'b0, 8'h00, 4'h0, 4'h0));
    tbl.push_back(nw(1'b1, 8'h11, 4'b0010, F_DROP));   // matched port busy
    tbl.push_back(nw(1'b1, 8'h55, 4'b0010, 4'h0));
    tbl.push_back(nw(1'b0, 8'h00, 4'h0, 4'h0));
    tbl.push_back(fw(8'h22, 4'h0));                    // other ports busy: ignored
    tbl.push_back(fw(8'hA5, 4'b1011));
    tbl.push_back(fw(8'h87, 4'b1011));
    tbl.push_back(nw(1'b0, 8'h00, 4'b1011, F_OK));
    tbl.push_back(nw(1'b0, 8'h00, 4'h0, 4'h0));

    rst_n = 1'b0;
    repeat (2) apply("reset", mk(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 8'h00, 4'h0));
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE);
    end

    for (int i = 0; i < tbl.size(); i++) apply($sformatf("table[%0d]", i), tbl[i]);

    // Duplicate address on ports 2 and 3: port 2 must win.
    port_addr = 32'h22_22_11_00;
    apply("dup_addr", fw(8'h22, 4'h0));
    apply("dup_b1", fw(8'hA5, 4'h0));
    apply("dup_b2", fw(8'h87, 4'h0));
    apply("dup_end", nw(1'b0, 8'h00, 4'h0, F_OK));
    port_addr = 32'h33_22_11_00;

    // Port 2 goes busy on beat 2 of a 5-beat packet.
    apply("busy_b1", fw(8'h22, 4'h0));
    apply("busy_b2", nw(1'b1, 8'h01, 4'b0100, F_DROP));
    apply("busy_b3", nw(1'b1, 8'h02, 4'b0100, 4'h0));
    apply("busy_b4", nw(1'b1, 8'h03, 4'b0100, 4'h0));
    apply("busy_b5", nw(1'b1, 8'h04, 4'b0100, 4'h0));
    apply("busy_gap", nw(1'b0, 8'h00, 4'h0, 4'h0));
    apply("after_busy_b1", fw(8'h22, 4'h0));
    apply("after_busy_b2", fw(8'hA5, 4'h0));
    apply("after_busy_b3", fw(8'h87, 4'h0));
    apply("after_busy_end", nw(1'b0, 8'h00, 4'h0, F_OK));

    // 6-beat packet with MAX_LEN=4; overflow beat also sees port busy.
    apply("long_b1", fw(8'h22, 4'h0));
    apply("long_b2", fw(8'h10, 4'h0));
    apply("long_b3", fw(8'h20, 4'h0));
    apply("long_b4", fw(8'h30, 4'h0));
    apply("long_b5", nw(1'b1, 8'h40, 4'b0100, F_LEN));
    apply("long_b6", nw(1'b1, 8'h50, 4'h0, 4'h0));
    apply("long_gap", nw(1'b0, 8'h00, 4'h0, 4'h0));

    // Exactly MAX_LEN beats, good parity 22^10^20^12 = 0.
    apply("max_b1", fw(8'h22, 4'h0));
    apply("max_b2", fw(8'h10, 4'h0));
    apply("max_b3", fw(8'h20, 4'h0));
    apply("max_b4", fw(8'h12, 4'h0));
    apply("max_end", nw(1'b0, 8'h00, 4'h0, F_OK));

    // 2-beat packet is too short.
    apply("short_b1", fw(8'h22, 4'h0));
    apply("short_b2", fw(8'h33, 4'h0));
    apply("short_end", nw(1'b0, 8'h00, 4'h0, F_LEN));

    // Reset mid-packet, packet still running after release is ignored.
    apply("rst_b1", fw(8'h22, 4'h0));
    apply("rst_b2", fw(8'h10, 4'h0));
    apply("rst_mid", mk(1'b0, 1'b1, 8'h20, 4'h0, 4'h0, 1'b1, 8'h00, 4'h0));
    apply("rst_held", nw(1'b1, 8'h22, 4'h0, 4'h0));
    apply("rst_held2", nw(1'b1, 8'h22, 4'h0, 4'h0));
    apply("rst_gap", nw(1'b0, 8'h00, 4'h0, 4'h0));
    apply("post_rst_b1", fw(8'h22, 4'h0));
    apply("post_rst_b2", fw(8'hA5, 4'h0));
    apply("post_rst_b3", fw(8'h87, 4'h0));
    apply("post_rst_end", nw(1'b0, 8'h00, 4'h0, F_OK));
    apply("idle_tail", nw(1'b0, 8'h00, 4'h0, 4'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/port_dispatch_fsm.md
PORT_DISPATCH_FSM -- requirements
Module: port_dispatch_fsm

Interface
REQ-001 Parameter W_WIDTH, default 8: width of data_in, data_out and each port address.
REQ-002 Parameter N_PORTS, default 4: number of output ports.
REQ-003 Parameter MAX_LEN, default 64: maximum packet length in beats, address and parity included.
REQ-004 clk  in  1  clock; all logic on posedge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 sw_en  in  1  packet-valid; high for every beat of a packet, low at least 1 cycle between packets.
REQ-007 data_in  in  W_WIDTH  beat data: first beat address, then data beats, last beat parity.
REQ-008 port_addr  in  N_PORTS*W_WIDTH  address of port i at bits [i*W_WIDTH +: W_WIDTH].
REQ-009 port_busy  in  N_PORTS  port i cannot accept a packet.
REQ-010 wr_en  out  N_PORTS  one-hot write strobe to the selected port.
REQ-011 data_out  out  W_WIDTH  forwarded beat, valid when any wr_en bit is high.
REQ-012 pkt_ok  out  1  one-cycle pulse: packet forwarded with good parity and length.
REQ-013 err_parity  out  1  one-cycle pulse: forwarded packet failed parity.
REQ-014 err_len  out  1  one-cycle pulse: packet shorter than 3 beats or longer than MAX_LEN.
REQ-015 err_drop  out  1  one-cycle pulse: packet dropped, no address match or port busy.

Function
REQ-016 States: IDLE, FWD, DROP; all outputs are registered.
REQ-017 IDLE, sw_en=1 at cycle t: data_in is compared against all port_addr entries; on duplicate matches the lowest index wins.
REQ-018 IDLE, match on port k with port_busy[k]=0: go to FWD; at t+1 wr_en[k]=1 and data_out = address beat.
REQ-019 IDLE, no match or matched port busy: go to DROP; err_drop pulses at t+1; wr_en stays 0.
REQ-020 FWD, sw_en=1 at cycle t: at t+1 wr_en[k]=1 and data_out=data_in; running XOR and beat count update.
REQ-021 Running parity is the XOR of all beats, address through parity; the packet is good when the final XOR is 0.
REQ-022 FWD, sw_en=0 at cycle t: at t+1 wr_en=0 and exactly one of the following pulses, then go to IDLE:
  - err_len if count < 3;
  - else err_parity if XOR != 0;
  - else pkt_ok.
REQ-023 FWD, port_busy[k]=1 with sw_en=1: wr_en=0 from the next cycle, err_drop pulses, go to DROP.
REQ-024 FWD, sw_en=1 on beat MAX_LEN+1: that beat is not forwarded, err_len pulses, go to DROP.
REQ-025 Simultaneous events in FWD: sw_en=0 has priority over port_busy; the length overflow has priority over port_busy.
REQ-026 DROP: wr_en=0; stay until sw_en=0, then go to IDLE the next cycle.
REQ-027 A packet can start in the cycle after the IDLE entry; back-to-back packets need only one sw_en=0 cycle between them.
REQ-028 port_busy of the non-selected ports is ignored during FWD.
REQ-029 At most one status pulse per packet; wr_en is always one-hot or zero.

Reset
REQ-030 rst_n=0 forces state IDLE, wr_en=0, data_out=0, all pulses 0, count=0 and XOR=0 at the next edge.
REQ-031 Reset mid-packet abandons the packet with no status pulse; a packet still in progress after reset release is not accepted until sw_en has been low for at least 1 cycle.

Structure
REQ-032 Shared package switch_pkg holds:
  - the state encoding constants (IDLE, FWD, DROP);
  - the default values of W_WIDTH, N_PORTS and MAX_LEN;
  - the minimum packet length constant, 3.
REQ-033 Beat counting is a sub-module, wd_cnt: a clear/increment counter, width clog2(MAX_LEN+2), with a ">MAX_LEN" flag.

Verification
REQ-034 port_addr={0x33,0x22,0x11,0x00}, beats 0x22,0xA5,0x87 with sw_en high: wr_en=0b0100 for 3 cycles with data 0x22,0xA5,0x87, then pkt_ok pulses.
REQ-035 Same packet but parity 0x00: 3 beats forwarded to port 2, then err_parity pulses, not pkt_ok.
REQ-036 Address 0x44 (no match), then separately address 0x11 with port_busy=0b0010: no wr_en, one err_drop pulse for each packet.
REQ-037 port_busy[2] rises on beat 2 of a 5-beat packet to port 2: wr_en drops, err_drop pulses, the next packet after the sw_en gap is accepted.
REQ-038 MAX_LEN=4, 6-beat packet: 4 beats forwarded, err_len pulses; a 2-beat packet also gives err_len; rst_n low mid-packet clears all outputs.
